// File: rtl/cac_dec_rr_sched_pkg.sv
// Shared FNS constants for the 27-bit CAC decoder path: decoded width and
// Fibonacci weight helper.
package cac_dec_rr_sched_pkg;

    // 27-bit codeword width accepted by the shared decoder
    localparam int FNS_CW  = 27;
    // Largest FNS value is F(29)-1 = 514228, which fits in 19 bits
    localparam int IBLEN27 = 19;

    // Weight of codeword bit k: F(k+1) with F(1)=F(2)=1, i.e. 1,1,2,3,5,...
    function automatic logic [IBLEN27-1:0] fns_weight(input int k);
        logic [IBLEN27-1:0] a;
        logic [IBLEN27-1:0] b;
        logic [IBLEN27-1:0] t;
        a = IBLEN27'(1);
        b = IBLEN27'(1);
        for (int i = 0; i < FNS_CW - 1; i++) begin
            if (i < k) begin
                t = a + b;
                a = b;
                b = t;
            end
        end
        return a;
    endfunction

endpackage

// File: rtl/cac_dec_rr_sched_idp_dec_27.sv
// Combinational FNS decoder: weighted sum of the 27 codeword bits.
// Every codeword is decoded; no legality check is made.
module IDP_dec_27
    import cac_dec_rr_sched_pkg::*;
(
    input  logic [FNS_CW-1:0]  codein,
    output logic [IBLEN27-1:0] binout
);

    // Accumulate the Fibonacci weight of every set bit at full width
    always_comb begin
        binout = '0;
        for (int k = 0; k < FNS_CW; k++) begin
            if (codein[k]) binout = binout + fns_weight(k);
        end
    end

endmodule

// File: rtl/cac_dec_rr_sched.sv
// Round-robin front end sharing one FNS CAC decoder among NCH channels.
// Two-stage pipeline: S1 holds the granted codeword, S2 the decoded word.
module cac_dec_rr_sched
    import cac_dec_rr_sched_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int CW   = 27,
    localparam int TAGW = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH*CW-1:0]    in_code,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IBLEN27-1:0]   out_data,
    output logic [TAGW-1:0]      out_ch,
    output logic                 busy
);

    if (CW != FNS_CW) begin : g_bad_cw
        $error("cac_dec_rr_sched: CW must be 27");
    end
    if (NCH < 2 || NCH > 8) begin : g_bad_nch
        $error("cac_dec_rr_sched: NCH must be 2..8");
    end

    // First valid channel at or after ptr, wrapping; MSB flags any request
    function automatic logic [TAGW:0] rr_pick(input logic [NCH-1:0] v,
                                              input logic [TAGW-1:0] ptr);
        logic [TAGW:0] r;
        int            idx;
        r = '0;
        // Scan farthest offset first so the nearest requester wins
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NCH;
            if (v[idx]) r = {1'b1, TAGW'(idx)};
        end
        return r;
    endfunction

    logic                s1_v_q, s1_v_d;
    logic [CW-1:0]       s1_code_q, s1_code_d;
    logic [TAGW-1:0]     s1_tag_q, s1_tag_d;
    logic                s2_v_q, s2_v_d;
    logic [IBLEN27-1:0]  s2_data_q, s2_data_d;
    logic [TAGW-1:0]     s2_tag_q, s2_tag_d;
    logic [TAGW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [TAGW:0]       pick;
    logic                any_req;
    logic [TAGW-1:0]     gnt;
    logic [CW-1:0]       gnt_code;
    logic                adv1, adv2, xfer;
    logic [IBLEN27-1:0]  dec_out;

    // Arbitration, stage-advance terms and the granted channel's codeword
    always_comb begin
        pick     = rr_pick(in_valid, rr_ptr_q);
        any_req  = pick[TAGW];
        gnt      = pick[TAGW-1:0];
        adv2     = !s2_v_q || out_ready;
        adv1     = !s1_v_q || adv2;
        xfer     = adv1 && rst_n && any_req;
        in_ready = '0;
        if (xfer) in_ready[gnt] = 1'b1;
        gnt_code = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt == TAGW'(i)) gnt_code = in_code[i*CW +: CW];
        end
    end

    IDP_dec_27 u_dec (
        .codein (s1_code_q),
        .binout (dec_out)
    );

    // Next state: S1 loads on a transfer, S2 loads from S1 when it may advance
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_code_d = s1_code_q;
        s1_tag_d  = s1_tag_q;
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_tag_d  = s2_tag_q;
        rr_ptr_d  = rr_ptr_q;
        if (adv1) s1_v_d = xfer;
        if (xfer) begin
            s1_code_d = gnt_code;
            s1_tag_d  = gnt;
            rr_ptr_d  = (gnt == TAGW'(NCH - 1)) ? '0 : gnt + 1'b1;
        end
        if (adv2) begin
            s2_v_d = s1_v_q;
            // Keep the last word on the outputs while the pipe is draining empty
            if (s1_v_q) begin
                s2_data_d = dec_out;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    // Pipeline and pointer registers; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_code_q <= '0;
            s1_tag_q  <= '0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_tag_q  <= '0;
            rr_ptr_q  <= '0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_code_q <= s1_code_d;
            s1_tag_q  <= s1_tag_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_tag_q  <= s2_tag_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_ch    = s2_tag_q;
    assign busy      = s1_v_q | s2_v_q;

endmodule
